// File: rtl/stack_pkg.sv
// Shared definitions for the clocked LIFO stack: pointer-width helper and
// bit positions of the packed {overflow,underflow,full,empty} status word.
package stack_pkg;

  localparam int unsigned ST_EMPTY     = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_UNDERFLOW = 2;
  localparam int unsigned ST_OVERFLOW  = 3;
  localparam int unsigned ST_W         = 4;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stack_mem.sv
// WIDTH x DEPTH stack storage: synchronous write, registered read with push bypass,
// and an async peek read port when STACK_PEEK_EN is defined.
module stack_mem
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rbyp,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
`ifdef STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    peek_addr,
  output logic [WIDTH-1:0] peek_rdata
`endif
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read samples the pre-write contents, so replace-top returns the old top.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= rbyp ? wdata : mem[raddr];
  end

`ifdef STACK_PEEK_EN
  assign peek_rdata = mem[peek_addr];
`endif

endmodule

// File: rtl/stack_sync.sv
// Clocked parametrised LIFO stack with occupancy, sticky error flags and replace-top.
// Optional peek read port enabled by defining STACK_PEEK_EN.
module stack_sync
  import stack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic [AW:0]      count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
`ifdef STACK_PEEK_EN
  ,
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data
`endif
);

  logic [AW:0]   count_n;
  logic          pop_valid_n, overflow_n, underflow_n;
  logic          we, re, rbyp;
  logic [AW-1:0] waddr, raddr;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // Next-state decode for pointer, flags and memory port controls.
  always_comb begin
    count_n     = count;
    pop_valid_n = 1'b0;
    overflow_n  = clr_err ? 1'b0 : overflow;
    underflow_n = clr_err ? 1'b0 : underflow;
    we          = 1'b0;
    re          = 1'b0;
    rbyp        = 1'b0;
    waddr       = AW'(count);
    raddr       = AW'(count - (AW+1)'(1));
    case ({push, pop})
      2'b10: begin
        if (full) begin
          overflow_n = 1'b1;
        end else begin
          we      = 1'b1;
          count_n = count + (AW+1)'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          underflow_n = 1'b1;
        end else begin
          re          = 1'b1;
          pop_valid_n = 1'b1;
          count_n     = count - (AW+1)'(1);
        end
      end
      2'b11: begin
        re          = 1'b1;
        pop_valid_n = 1'b1;
        if (empty) begin
          rbyp = 1'b1;
        end else begin
          we    = 1'b1;
          waddr = raddr;
        end
      end
      default: ;
    endcase
    if (rst) begin
      we = 1'b0;
      re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_n;
      pop_valid <= pop_valid_n;
      overflow  <= overflow_n;
      underflow <= underflow_n;
    end
  end

`ifdef STACK_PEEK_EN
  logic [AW-1:0]    peek_addr;
  logic [WIDTH-1:0] peek_rdata;
  logic             peek_ok;

  assign peek_ok   = ((AW+1)'(peek_idx) < count);
  assign peek_addr = AW'(count - (AW+1)'(1) - (AW+1)'(peek_idx));
  assign peek_data = peek_ok ? peek_rdata : '0;
`endif

  stack_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (push_data),
    .re        (re),
    .rbyp      (rbyp),
    .raddr     (raddr),
    .rdata     (pop_data)
`ifdef STACK_PEEK_EN
    ,
    .peek_addr (peek_addr),
    .peek_rdata(peek_rdata)
`endif
  );

endmodule
